// File: rtl/pulse_scheduler_pkg.sv
// Shared types for the pulse scheduler: descriptor layout, FSM state
// encoding and the effective-delay helper.
package pulse_scheduler_pkg;

   localparam int PULSE_REG_TSTART_W = 16;
   localparam int PULSE_MEM_ADDR_W   = 8;

   typedef struct packed {
      logic [PULSE_REG_TSTART_W-1:0] delay;
      logic [PULSE_MEM_ADDR_W-1:0]   pulse_mem_addr;
   } pulse_descriptor_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_FIRE = 2'd2
   } pulse_sched_state_t;

   // A zero delay behaves like a delay of one: back-to-back issues.
   function automatic logic [PULSE_REG_TSTART_W-1:0] eff_delay(
      input logic [PULSE_REG_TSTART_W-1:0] d);
      return (d == '0) ? {{(PULSE_REG_TSTART_W-1){1'b0}}, 1'b1} : d;
   endfunction

endpackage

// File: rtl/pulse_desc_fifo.sv
// Synchronous descriptor FIFO, DEPTH entries of pulse_descriptor_t.
// Ports:
//   i_clk, i_reset_n (sync, active-low), i_flush (drop contents)
//   i_push/i_data    write side (caller guarantees !o_full)
//   i_pop            read side  (caller guarantees !o_empty)
//   o_head           oldest entry, valid when !o_empty
//   o_full, o_empty, o_count
module pulse_desc_fifo
   import pulse_scheduler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_flush,
   input  logic                        i_push,
   input  pulse_descriptor_t           i_data,
   input  logic                        i_pop,
   output pulse_descriptor_t           o_head,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [$clog2(DEPTH):0]      o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   pulse_descriptor_t r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
         if (i_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
         case ({i_push, i_pop})
            2'b10:   r_count <= CNT_W'(r_count + 1'b1);
            2'b01:   r_count <= CNT_W'(r_count - 1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/pulse_scheduler.sv
// Releases queued pulse descriptors to the playback engine so that each
// play_valid rises `delay` cycles after the previous handshake; flags and
// counts descriptors that arrive after their slot.
// Ports:
//   i_clk, i_reset_n (sync, active-low), i_run (timeline enable), i_flush
//   i_in_desc/i_in_valid/o_in_ready      descriptor input (FIFO read side)
//   o_play_addr/o_play_valid/i_play_ready issue to playback engine
//   o_busy        queue non-empty or issue pending
//   o_late_pulse  1-cycle strobe, coincident with a late play_valid rise
//   o_issued_count, o_late_count  saturating debug counters
//
// state  | meaning
// S_IDLE | timeline not started; elapsed held at 0
// S_WAIT | counting elapsed toward the head descriptor's slot
// S_FIRE | play_valid raised, holding address until play_ready
module pulse_scheduler
   import pulse_scheduler_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_run,
   input  logic                        i_flush,
   input  pulse_descriptor_t           i_in_desc,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   output logic [PULSE_MEM_ADDR_W-1:0] o_play_addr,
   output logic                        o_play_valid,
   input  logic                        i_play_ready,
   output logic                        o_busy,
   output logic                        o_late_pulse,
   output logic [CNT_W-1:0]            o_issued_count,
   output logic [CNT_W-1:0]            o_late_count
);

   localparam int DELAY_W = PULSE_REG_TSTART_W;
   localparam int ADDR_W  = PULSE_MEM_ADDR_W;

   pulse_sched_state_t      r_state;
   pulse_sched_state_t      w_state_nxt;
   logic [DELAY_W-1:0]      r_elapsed;
   logic [ADDR_W-1:0]       r_play_addr;
   logic                    r_play_valid;
   logic                    r_late_pulse;
   logic [CNT_W-1:0]        r_issued_count;
   logic [CNT_W-1:0]        r_late_count;

   pulse_descriptor_t       w_head;
   logic                    w_full;
   logic                    w_empty;
   logic [$clog2(DEPTH):0]  w_count;
   logic                    w_push;
   logic                    w_fire;
   logic                    w_late;
   logic                    w_hs;
   logic [DELAY_W:0]        w_due;
   logic [DELAY_W:0]        w_dly;

   assign o_in_ready = i_reset_n && !i_flush && !w_full;
   assign w_push     = i_in_valid && o_in_ready;
   assign w_hs       = (r_state == S_FIRE) && r_play_valid && i_play_ready && !i_flush;

   // w_due is the elapsed value at the cycle play_valid would rise if we
   // fired now; a registered issue lands one cycle after the decision.
   assign w_due = {1'b0, r_elapsed} + 1'b1;
   assign w_dly = {1'b0, eff_delay(w_head.delay)};

   pulse_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_flush   (i_flush),
      .i_push    (w_push),
      .i_data    (i_in_desc),
      .i_pop     (w_fire),
      .o_head    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      w_late      = 1'b0;
      if (i_flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_run && !w_empty) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (i_run && !w_empty && (w_due >= w_dly)) begin
                  w_fire      = 1'b1;
                  w_late      = (w_due > w_dly);
                  w_state_nxt = S_FIRE;
               end
            end
            S_FIRE: begin
               // The handshake cycle is elapsed 0, so only a one-cycle slot
               // can chain straight into the next issue, and it is never late.
               if (w_hs) begin
                  if (i_run && !w_empty && (w_dly == (DELAY_W+1)'(1))) begin
                     w_fire      = 1'b1;
                     w_state_nxt = S_FIRE;
                  end else begin
                     w_state_nxt = S_WAIT;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_elapsed      <= '0;
         r_play_addr    <= '0;
         r_play_valid   <= 1'b0;
         r_late_pulse   <= 1'b0;
         r_issued_count <= '0;
         r_late_count   <= '0;
      end else if (i_flush) begin
         r_elapsed    <= '0;
         r_play_valid <= 1'b0;
         r_late_pulse <= 1'b0;
      end else begin
         r_late_pulse <= w_fire && w_late;
         if (w_fire) begin
            r_play_addr  <= w_head.pulse_mem_addr;
            r_play_valid <= 1'b1;
         end else if (w_hs) begin
            r_play_valid <= 1'b0;
         end

         if (r_state == S_IDLE) begin
            r_elapsed <= '0;
         end else if (w_hs) begin
            r_elapsed <= i_run ? DELAY_W'(1) : '0;
         end else if (i_run && (r_elapsed != '1)) begin
            r_elapsed <= DELAY_W'(r_elapsed + 1'b1);
         end

         if (w_hs && (r_issued_count != '1))
            r_issued_count <= CNT_W'(r_issued_count + 1'b1);
         if (w_fire && w_late && (r_late_count != '1))
            r_late_count <= CNT_W'(r_late_count + 1'b1);
      end
   end

   assign o_play_addr    = r_play_addr;
   assign o_play_valid   = r_play_valid;
   assign o_late_pulse   = r_late_pulse;
   assign o_issued_count = r_issued_count;
   assign o_late_count   = r_late_count;
   assign o_busy         = (w_count != '0) || r_play_valid;

endmodule

// File: tb/tb_pulse_scheduler.sv
module tb_pulse_scheduler;
   import pulse_scheduler_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              i_reset_n, i_run, i_flush, i_in_valid, i_play_ready;
   pulse_descriptor_t i_in_desc;
   logic              o_in_ready, o_play_valid, o_busy, o_late_pulse;
   logic [7:0]        o_play_addr;
   logic [CNT_W-1:0]  o_issued_count, o_late_count;

   always #5 clk = ~clk;

   pulse_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .i_clk          (clk),
      .i_reset_n      (i_reset_n),
      .i_run          (i_run),
      .i_flush        (i_flush),
      .i_in_desc      (i_in_desc),
      .i_in_valid     (i_in_valid),
      .o_in_ready     (o_in_ready),
      .o_play_addr    (o_play_addr),
      .o_play_valid   (o_play_valid),
      .i_play_ready   (i_play_ready),
      .o_busy         (o_busy),
      .o_late_pulse   (o_late_pulse),
      .o_issued_count (o_issued_count),
      .o_late_count   (o_late_count)
   );

   typedef struct {
      logic [7:0] addr;
      int         gap;   // cycles since previous handshake, -1 = unchecked
      bit         late;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_hs = 0;
   bit   late_seen = 1'b0;

   task automatic chk(input string name, input longint act, input longint expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every handshake consumes one expected issue.
   always @(negedge clk) begin
      if (i_reset_n) begin
         if (i_flush) late_seen = 1'b0;
         if (o_late_pulse) late_seen = 1'b1;
         if (o_play_valid && i_play_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_issue: got addr %02h expected none", o_play_addr);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("play_addr", o_play_addr, e.addr);
               if (e.gap >= 0) chk("issue_gap", cyc - last_hs, e.gap);
               chk("late_flag", late_seen, e.late);
            end
            last_hs   = cyc;
            late_seen = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int dly, input int addr, input bit expect_issue,
                       input int gap, input bit late);
      exp_t e;
      i_in_desc.delay          = 16'(dly);
      i_in_desc.pulse_mem_addr = 8'(addr);
      i_in_valid = 1'b1;
      if (expect_issue) begin
         e.addr = 8'(addr);
         e.gap  = gap;
         e.late = late;
         exp_q.push_back(e);
      end
      tick();
      i_in_valid = 1'b0;
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
   endtask

   task automatic wait_issued(input int target);
      for (int i = 0; i < 100 && o_issued_count != CNT_W'(target); i++) tick();
      chk("issued_count", o_issued_count, target);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 30 && !o_play_valid; i++) tick();
      chk("play_valid_rise", o_play_valid, 1);
   endtask

   initial begin
      int pv_cnt;
      bit stable;
      i_reset_n = 1'b0; i_run = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0;
      i_play_ready = 1'b1; i_in_desc = '0;
      #1;
      chk("in_ready_in_reset", o_in_ready, 0);
      tick(); tick();
      chk("rst_play_valid", o_play_valid, 0);
      chk("rst_play_addr", o_play_addr, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_late_pulse", o_late_pulse, 0);
      chk("rst_issued", o_issued_count, 0);
      chk("rst_late", o_late_count, 0);
      i_reset_n = 1'b1;
      #1;
      chk("in_ready_after_reset", o_in_ready, 1);
      pv_cnt = 0;
      repeat (10) begin tick(); pv_cnt += int'(o_play_valid); end
      chk("idle_no_issue", pv_cnt, 0);

      // relative timing: second issue 8 cycles after first handshake
      push(5, 8'h03, 1'b1, -1, 1'b0);
      push(8, 8'h07, 1'b1, 8, 1'b0);
      wait_issued(2);
      chk("late_after_t2", o_late_count, 0);

      // zero/one delays chain on consecutive cycles
      do_flush();
      push(0, 8'h01, 1'b1, -1, 1'b0);
      push(0, 8'h02, 1'b1, 1, 1'b0);
      push(1, 8'h03, 1'b1, 1, 1'b0);
      wait_issued(5);
      chk("late_after_t3", o_late_count, 0);

      // arrival 10 cycles after the last handshake: issued at once, late
      repeat (9) tick();
      push(4, 8'h09, 1'b1, 12, 1'b1);
      wait_issued(6);
      chk("late_after_t4", o_late_count, 1);

      // fill the queue with the engine stalled
      i_play_ready = 1'b0;
      i_run = 1'b0;
      do_flush();
      for (int k = 0; k < DEPTH; k++)
         push(1, 8'h10 + k, 1'b1, (k == 0) ? -1 : 1, 1'b0);
      chk("in_ready_full", o_in_ready, 0);
      chk("busy_full", o_busy, 1);
      push(1, 8'h99, 1'b0, 0, 1'b0);
      i_run = 1'b1;
      wait_valid();
      stable = 1'b1;
      repeat (5) begin
         tick();
         if (!o_play_valid || o_play_addr != 8'h10) stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
      i_play_ready = 1'b1;
      wait_issued(6 + DEPTH);

      // flush with an issue pending and three entries queued
      i_play_ready = 1'b0;
      i_run = 1'b0;
      do_flush();
      for (int k = 0; k < DEPTH; k++) push(1, 8'h20 + k, 1'b0, 0, 1'b0);
      i_run = 1'b1;
      wait_valid();
      chk("busy_before_flush", o_busy, 1);
      i_flush = 1'b1;
      #1;
      chk("in_ready_flush", o_in_ready, 0);
      tick();
      i_flush = 1'b0;
      chk("flush_play_valid", o_play_valid, 0);
      chk("flush_busy", o_busy, 0);
      chk("flush_issued", o_issued_count, 6 + DEPTH);
      chk("flush_late", o_late_count, 1);
      i_play_ready = 1'b1;
      repeat (10) tick();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
